// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes, FSM
// state types and the address/byte-lane helper functions.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  // Register index from a byte address; the two low address bits are ignored.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                              input logic [31:0] mask);
    return (addr & mask) >> 2;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] oval,
                                             input logic [31:0] nval,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = oval;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = nval[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle for the register bank (slave side is the bank).
interface axil_reg_bank_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_sticky_status.sv
// Per-bit sticky latches for the status registers; a cleared register reloads
// from the live inputs so a set arriving with the clear is kept.
module axil_sticky_status #(
  parameter int                       SREG_COUNT  = 4,
  parameter logic [SREG_COUNT*32-1:0] STICKY_MASK = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SREG_COUNT*32-1:0] i_status,
  input  logic [SREG_COUNT-1:0]   i_clear,
  output logic [SREG_COUNT*32-1:0] o_status
);

  logic [SREG_COUNT*32-1:0] latch;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      latch <= '0;
    end else begin
      for (int s = 0; s < SREG_COUNT; s++) begin
        if (i_clear[s])
          latch[32*s +: 32] <= i_status[32*s +: 32] & STICKY_MASK[32*s +: 32];
        else
          latch[32*s +: 32] <= (latch[32*s +: 32] | i_status[32*s +: 32]) &
                               STICKY_MASK[32*s +: 32];
      end
    end
  end

  // Latch only ever holds sticky bits, so a plain OR merges both kinds.
  assign o_status = latch | i_status;

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: SREG_COUNT read-only status registers followed by
// CREG_COUNT byte-writable control registers, independent read/write paths.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                       SREG_COUNT    = 4,
  parameter int                       CREG_COUNT    = 6,
  parameter logic [CREG_COUNT*32-1:0] CREG_DEFAULTS = '0,
  parameter logic [SREG_COUNT*32-1:0] STICKY_MASK   = '0,
  parameter logic [31:0]              ADDR_MASK     = 32'h7F
) (
  input  logic                             clk,
  input  logic                             resetn,
  axil_reg_bank_if.slave                   s_axi,
  input  logic [SREG_COUNT*32-1:0]         i_status,
  output logic [CREG_COUNT*32-1:0]         o_control,
  output logic [CREG_COUNT-1:0]            o_wstrobe,
  output logic [SREG_COUNT+CREG_COUNT-1:0] o_rstrobe
);

  localparam int NREG = SREG_COUNT + CREG_COUNT;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic        aw_ready, w_ready, ar_ready;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] creg [CREG_COUNT];

  logic        aw_hs, w_hs, ar_hs, wr_exec;
  logic [31:0] wr_addr, wr_data, wr_idx;
  logic [3:0]  wr_strb;
  logic [31:0] rd_idx, rd_val;
  logic [1:0]  rd_resp;
  logic [NREG-1:0] rd_hit;
  logic [SREG_COUNT*32-1:0] status_merged;
  logic [SREG_COUNT-1:0]    sticky_clr;

  assign aw_hs = s_axi.S_AXI_AWVALID & aw_ready;
  assign w_hs  = s_axi.S_AXI_WVALID  & w_ready;
  assign ar_hs = s_axi.S_AXI_ARVALID & ar_ready;

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_BVALID  = (wr_state == WR_RESP);
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RVALID  = (rd_state == RD_RESP);

  always_comb begin
    for (int k = 0; k < CREG_COUNT; k++) o_control[32*k +: 32] = creg[k];
  end

  // ---- write path: address/data may arrive in either order ----
  always_comb begin
    wr_next = wr_state;
    wr_exec = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next = WR_RESP;
          wr_exec = 1'b1;
        end else if (aw_hs) begin
          wr_next = WR_WAIT_W;
        end else if (w_hs) begin
          wr_next = WR_WAIT_AW;
        end
      end
      WR_WAIT_W: begin
        if (w_hs) begin
          wr_next = WR_RESP;
          wr_exec = 1'b1;
        end
      end
      WR_WAIT_AW: begin
        if (aw_hs) begin
          wr_next = WR_RESP;
          wr_exec = 1'b1;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign wr_addr = (wr_state == WR_WAIT_W)  ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = (wr_state == WR_WAIT_AW) ? wdata_q  : s_axi.S_AXI_WDATA;
  assign wr_strb = (wr_state == WR_WAIT_AW) ? wstrb_q  : s_axi.S_AXI_WSTRB;
  assign wr_idx  = addr_to_idx(wr_addr, ADDR_MASK);

  always_ff @(posedge clk) begin
    if (!resetn) wr_state <= WR_IDLE;
    else         wr_state <= wr_next;
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= s_axi.S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= s_axi.S_AXI_WDATA;
      wstrb_q <= s_axi.S_AXI_WSTRB;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_ready  <= 1'b0;
      w_ready   <= 1'b0;
      bresp     <= OKAY;
      o_wstrobe <= '0;
      for (int k = 0; k < CREG_COUNT; k++) creg[k] <= CREG_DEFAULTS[32*k +: 32];
    end else begin
      // Ready tracks which half of the transaction is still outstanding.
      aw_ready  <= (wr_next == WR_IDLE) || (wr_next == WR_WAIT_AW);
      w_ready   <= (wr_next == WR_IDLE) || (wr_next == WR_WAIT_W);
      o_wstrobe <= '0;
      if (wr_exec) begin
        if (wr_idx < 32'(SREG_COUNT))  bresp <= SLVERR;
        else if (wr_idx < 32'(NREG))   bresp <= OKAY;
        else                           bresp <= DECERR;
        for (int k = 0; k < CREG_COUNT; k++) begin
          if (wr_idx == 32'(SREG_COUNT + k) && wr_strb != 4'b0000) begin
            creg[k]      <= byte_merge(creg[k], wr_data, wr_strb);
            o_wstrobe[k] <= 1'b1;
          end
        end
      end
    end
  end

  // ---- read path ----
  axil_sticky_status #(
    .SREG_COUNT  (SREG_COUNT),
    .STICKY_MASK (STICKY_MASK)
  ) u_sticky (
    .clk      (clk),
    .resetn   (resetn),
    .i_status (i_status),
    .i_clear  (sticky_clr),
    .o_status (status_merged)
  );

  assign rd_idx = addr_to_idx(s_axi.S_AXI_ARADDR, ADDR_MASK);

  always_comb begin
    rd_val  = '0;
    rd_resp = DECERR;
    rd_hit  = '0;
    for (int n = 0; n < SREG_COUNT; n++) begin
      if (rd_idx == 32'(n)) begin
        rd_val    = status_merged[32*n +: 32];
        rd_resp   = OKAY;
        rd_hit[n] = 1'b1;
      end
    end
    for (int k = 0; k < CREG_COUNT; k++) begin
      if (rd_idx == 32'(SREG_COUNT + k)) begin
        rd_val               = creg[k];
        rd_resp              = OKAY;
        rd_hit[SREG_COUNT+k] = 1'b1;
      end
    end
  end

  assign sticky_clr = ar_hs ? rd_hit[SREG_COUNT-1:0] : '0;

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) rd_state <= RD_IDLE;
    else         rd_state <= rd_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_ready  <= 1'b0;
      rdata     <= '0;
      rresp     <= OKAY;
      o_rstrobe <= '0;
    end else begin
      ar_ready  <= (rd_next == RD_IDLE);
      o_rstrobe <= '0;
      if (ar_hs) begin
        rdata     <= rd_val;
        rresp     <= rd_resp;
        o_rstrobe <= rd_hit;
      end
    end
  end

endmodule
